// File: rtl/crypto_engine_pkg.sv
// Shared types and helpers for the iterative block-cipher engine.
// This file holds the FSM state enum, the width-parametrised byte rotates and the round-counter width.
package crypto_engine_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  function automatic int ctr_width(input int rounds);
    return (rounds > 1) ? $clog2(rounds) : 1;
  endfunction

  // A parametrised class gives width-generic byte rotates without a fixed maximum width.
  virtual class byte_rot #(parameter int W = 32);
    static function logic [W-1:0] rotl8(input logic [W-1:0] x);
      return {x[W-9:0], x[W-1:W-8]};
    endfunction

    static function logic [W-1:0] rotr8(input logic [W-1:0] x);
      return {x[7:0], x[W-1:8]};
    endfunction
  endclass

endpackage

// File: rtl/crypto_round_fn.sv
// Combinational single cipher round.
// Encrypt computes rotl8(s ^ k). Decrypt computes rotr8(s) ^ k, which undoes one encrypt round.
module crypto_round_fn
  import crypto_engine_pkg::*;
#(
  parameter int W = 128
) (
  input  logic [W-1:0] i_state,
  input  logic [W-1:0] i_key,
  input  logic         i_decrypt,
  output logic [W-1:0] o_next
);

  always_comb begin
    o_next = '0;
    if (i_decrypt) o_next = byte_rot#(W)::rotr8(i_state) ^ i_key;
    else           o_next = byte_rot#(W)::rotl8(i_state ^ i_key);
  end

endmodule

// File: rtl/crypto_round_engine.sv
// Iterative block-cipher engine with valid/ready streaming, runtime encrypt/decrypt selection,
// optional IV chaining and output back-pressure. It processes one block at a time: IDLE -> ROUND x R -> DONE.
module crypto_round_engine
  import crypto_engine_pkg::*;
#(
  parameter int                       BLOCK_BYTES = 16,
  parameter int                       ROUND_COUNT = 8,
  parameter logic [8*BLOCK_BYTES-1:0] IV_SEED     = {BLOCK_BYTES{8'hA5}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8*BLOCK_BYTES-1:0]   in_data,
  input  logic [8*BLOCK_BYTES-1:0]   in_key,
  input  logic                       in_decrypt,
  input  logic                       in_chain,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*BLOCK_BYTES-1:0]   out_data,
  output logic                       out_decrypt,
  output logic                       busy
);

  localparam int            W         = 8 * BLOCK_BYTES;
  localparam int            CW        = ctr_width(ROUND_COUNT);
  localparam logic [CW-1:0] LAST      = CW'(ROUND_COUNT - 1);
  localparam int            DEC_STEPS = (ROUND_COUNT - 1) % BLOCK_BYTES;

  state_t        r_state;
  logic [W-1:0]  r_data;
  logic [W-1:0]  r_key;
  logic [CW-1:0] r_cnt;
  logic          r_dec;
  logic          r_chn;
  logic [W-1:0]  r_cin;
  logic [W-1:0]  r_chain;
  logic          r_outValid;
  logic [W-1:0]  r_outData;
  logic          r_outDec;

  logic [W-1:0]  w_next;
  logic [W-1:0]  w_keyLast;
  logic [W-1:0]  w_result;
  logic          w_lastRound;
  logic          w_outFree;

  crypto_round_fn #(.W(W)) u_round (
    .i_state   (r_data),
    .i_key     (r_key),
    .i_decrypt (r_dec),
    .o_next    (w_next)
  );

  // Decryption starts from the last round key k_{R-1} = rotr(K, 8*(R-1) mod W).
  always_comb begin
    w_keyLast = in_key;
    for (int i = 0; i < DEC_STEPS; i++) w_keyLast = byte_rot#(W)::rotr8(w_keyLast);
  end

  assign w_result    = r_dec ? (r_data ^ (r_chn ? r_chain : '0)) : r_data;
  assign w_lastRound = r_dec ? (r_cnt == '0) : (r_cnt == LAST);
  assign w_outFree   = !r_outValid || out_ready;

  // Round keys are stepped by a single byte rotation per round rather than recomputed from K.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_key      <= '0;
      r_cnt      <= '0;
      r_dec      <= 1'b0;
      r_chn      <= 1'b0;
      r_cin      <= '0;
      r_chain    <= IV_SEED;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outDec   <= 1'b0;
    end else begin
      if (r_outValid && out_ready) r_outValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data  <= in_decrypt ? in_data : (in_data ^ (in_chain ? r_chain : '0));
            r_key   <= in_decrypt ? w_keyLast : in_key;
            r_cnt   <= in_decrypt ? LAST : '0;
            r_dec   <= in_decrypt;
            r_chn   <= in_chain;
            r_cin   <= in_data;
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_data <= w_next;
          r_key  <= r_dec ? byte_rot#(W)::rotl8(r_key) : byte_rot#(W)::rotr8(r_key);
          if (w_lastRound) r_state <= DONE;
          else             r_cnt   <= r_dec ? (r_cnt - 1'b1) : (r_cnt + 1'b1);
        end
        DONE: begin
          // A pop in the same cycle frees the slot, so the new result overwrites and out_valid stays high.
          if (w_outFree) begin
            r_outData  <= w_result;
            r_outValid <= 1'b1;
            r_outDec   <= r_dec;
            if (r_chn) r_chain <= r_dec ? r_cin : r_data;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign out_valid   = r_outValid;
  assign out_data    = r_outData;
  assign out_decrypt = r_outDec;

endmodule

// File: tb/tb_crypto_round_engine.sv
// Self-checking bench for crypto_round_engine: table vectors, scoreboard, stall, mid-round reset,
// and round-trips on a second instance that uses the default 16-byte, 8-round configuration.
module tb_crypto_round_engine;

  localparam int          BB = 4;
  localparam int          RC = 2;
  localparam logic [31:0] IV = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_decrypt, in_chain;
  logic        out_valid, out_ready, out_decrypt, busy;
  logic [31:0] in_data, in_key, out_data;

  crypto_round_engine #(.BLOCK_BYTES(BB), .ROUND_COUNT(RC), .IV_SEED(IV)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .in_decrypt(in_decrypt), .in_chain(in_chain),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_decrypt(out_decrypt), .busy(busy)
  );

  logic         bInValid, bInReady, bInDecrypt, bInChain, bOutValid, bOutReady, bOutDecrypt, bBusy;
  logic [127:0] bInData, bInKey, bOutData;

  crypto_round_engine dutDefault (
    .clk(clk), .rst(rst),
    .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData), .in_key(bInKey),
    .in_decrypt(bInDecrypt), .in_chain(bInChain),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
    .out_decrypt(bOutDecrypt), .busy(bBusy)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic        dec;
  } sbEntry_t;
  sbEntry_t    sbQ[$];
  logic [31:0] tbChain = IV;

  typedef struct {
    logic [31:0] data;
    logic [31:0] key;
    logic        dec;
    logic        chn;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic checkValue(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] rotBytesRight(input logic [31:0] x, input int n);
    logic [31:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[7:0], y[31:8]};
    return y;
  endfunction

  function automatic logic [31:0] rotBytesLeft(input logic [31:0] x, input int n);
    logic [31:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[23:0], y[31:24]};
    return y;
  endfunction

  // Reference cipher written straight from the round definitions, each round key derived from K.
  function automatic logic [31:0] modelCipher(input logic [31:0] d, input logic [31:0] k,
                                              input logic dec, input logic [31:0] mask);
    logic [31:0] s;
    if (!dec) begin
      s = d ^ mask;
      for (int i = 0; i < RC; i++) s = rotBytesLeft(s ^ rotBytesRight(k, i % BB), 1);
    end else begin
      s = d;
      for (int i = RC - 1; i >= 0; i--) s = rotBytesRight(s, 1) ^ rotBytesRight(k, i % BB);
      s = s ^ mask;
    end
    return s;
  endfunction

  // Scoreboard: push the model result on every accept, pop and compare on every output handshake.
  always @(negedge clk) begin
    sbEntry_t e;
    if (rst) begin
      sbQ.delete();
      tbChain = IV;
    end else begin
      if (out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL sb_unexpected: got %0h expected no output", out_data);
        end else begin
          e = sbQ.pop_front();
          checkValue("sb_data", out_data, e.data);
          checkValue("sb_decrypt", out_decrypt, e.dec);
        end
      end
      if (in_valid && in_ready) begin
        e.data = modelCipher(in_data, in_key, in_decrypt, in_chain ? tbChain : 32'h0);
        e.dec  = in_decrypt;
        sbQ.push_back(e);
        if (in_chain) tbChain = in_decrypt ? in_data : e.data;
      end
    end
  end

  task automatic waitAccept();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [31:0] k, input logic dec, input logic chn);
    @(posedge clk);
    #1;
    in_data    = d;
    in_key     = k;
    in_decrypt = dec;
    in_chain   = chn;
    in_valid   = 1'b1;
    waitAccept();
  endtask

  // Called at the accepting edge + #1; that edge counts as edge 1 for the latency figure.
  task automatic checkOutput(input string name, input logic [31:0] expData, input logic expDec, input int expEdges);
    int edges;
    edges = 1;
    while (!out_valid && edges < 64) begin
      @(posedge clk);
      #1 edges++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got out_valid=0 expected 1", name);
    end else begin
      if (expEdges > 0) checkValue({name, "_latency"}, edges, expEdges);
      checkValue({name, "_data"}, out_data, expData);
      checkValue({name, "_decrypt"}, out_decrypt, expDec);
    end
  endtask

  task automatic driveDefault(input logic [127:0] d, input logic [127:0] k, input logic dec,
                              output logic [127:0] res, output bit ok);
    bit acc;
    int n;
    @(posedge clk);
    #1;
    bInData = d; bInKey = k; bInDecrypt = dec; bInValid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (bInReady) acc = 1'b1;
    end
    @(posedge clk);
    #1 bInValid = 1'b0;
    n = 0;
    while (!bOutValid && n < 64) begin
      @(posedge clk);
      #1 n++;
    end
    res = bOutData;
    ok  = acc && bOutValid;
  endtask

  task automatic roundTripDefault(input int idx);
    logic [127:0] p, k, c, r;
    bit ok1, ok2;
    p = {$urandom(), $urandom(), $urandom(), $urandom()};
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    driveDefault(p, k, 1'b0, c, ok1);
    driveDefault(c, k, 1'b1, r, ok2);
    if (!ok1 || !ok2) begin
      total++;
      bad++;
      $display("[TB] FAIL rt128_%0d_timeout: got no output expected a result", idx);
    end else begin
      checkValue($sformatf("rt128_%0d", idx), r, p);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] p, k, c;

    vecs[0] = '{32'h00000000, 32'h01020304, 1'b0, 1'b0, 32'h02060206};
    vecs[1] = '{32'h02060206, 32'h01020304, 1'b1, 1'b0, 32'h00000000};
    vecs[2] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'hA5A5A5A5};
    vecs[3] = '{32'hA5A5A5A5, 32'h00000000, 1'b0, 1'b1, 32'h00000000};
    vecs[4] = '{32'hA5A5A5A5, 32'h00000000, 1'b1, 1'b1, 32'hA5A5A5A5};
    vecs[5] = '{32'h11111111, 32'h00000000, 1'b0, 1'b1, 32'hB4B4B4B4};

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_key = '0; in_decrypt = 1'b0; in_chain = 1'b0; out_ready = 1'b1;
    bInValid = 1'b0; bInData = '0; bInKey = '0; bInDecrypt = 1'b0; bInChain = 1'b0; bOutReady = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkValue("rst_out_valid", out_valid, 0);
    checkValue("rst_out_data", out_data, 0);
    checkValue("rst_out_decrypt", out_decrypt, 0);
    checkValue("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkValue("post_rst_in_ready", in_ready, 1);

    // Back-pressure: A parks in the output register, B stalls in DONE, C is held by the producer.
    out_ready = 1'b0;
    applyStimulus(32'h00000000, 32'h01020304, 1'b0, 1'b0);
    checkOutput("stall_a", 32'h02060206, 1'b0, RC + 2);
    applyStimulus(32'h02060206, 32'h01020304, 1'b1, 1'b0);
    in_data = 32'h12345678; in_key = 32'h0; in_decrypt = 1'b0; in_chain = 1'b0; in_valid = 1'b1;
    repeat (8) @(negedge clk);
    checkValue("stall_in_ready", in_ready, 0);
    checkValue("stall_busy", busy, 1);
    checkValue("stall_out_valid", out_valid, 1);
    checkValue("stall_hold_data", out_data, 32'h02060206);
    checkValue("stall_hold_decrypt", out_decrypt, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    waitAccept();
    checkOutput("stall_c", 32'h56781234, 1'b0, RC + 2);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].data, vecs[i].key, vecs[i].dec, vecs[i].chn);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp, vecs[i].dec, RC + 2);
    end

    for (int i = 0; i < 4; i++) begin
      p = $urandom();
      k = $urandom();
      applyStimulus(p, k, 1'b0, 1'b0);
      checkOutput($sformatf("rt32_enc%0d", i), modelCipher(p, k, 1'b0, 32'h0), 1'b0, 0);
      c = out_data;
      applyStimulus(c, k, 1'b1, 1'b0);
      checkOutput($sformatf("rt32_dec%0d", i), p, 1'b1, 0);
    end

    // Reset in the middle of the ROUND state discards the block and restores the chain seed.
    applyStimulus(32'h00000000, 32'h01020304, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkValue("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    checkValue("mid_rst_out_valid", out_valid, 0);
    checkValue("mid_rst_out_data", out_data, 0);
    checkValue("mid_rst_busy", busy, 0);
    checkValue("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checkValue("after_rst_in_ready", in_ready, 1);
    checkValue("after_rst_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    checkValue("discarded_out_valid", out_valid, 0);
    applyStimulus(32'h00000000, 32'h00000000, 1'b0, 1'b1);
    checkOutput("chain_reseed", IV, 1'b0, RC + 2);
    applyStimulus(32'h00000000, 32'h01020304, 1'b0, 1'b0);
    checkOutput("post_rst_enc", 32'h02060206, 1'b0, RC + 2);

    for (int i = 0; i < 3; i++) roundTripDefault(i);

    repeat (4) @(posedge clk);
    #1;
    checkValue("sb_drained", sbQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crypto_round_engine.md
Name: crypto_round_engine

Overview:
Parametrised iterative block-cipher engine for crypto host circuits. It replaces the fixed 16-byte/8-round start/done core with four additions: a valid/ready streaming interface, runtime encrypt/decrypt selection, an optional IV-chained (CBC-style) mode, and output back-pressure with stall. It sits between the host's plaintext source and its ciphertext consumer, and processes one block at a time.

Parameters:
BLOCK_BYTES, 16, block and key size in bytes (>=2); W = 8*BLOCK_BYTES.
ROUND_COUNT, 8, rounds per block (>=1); round counter width = max(1, $clog2(ROUND_COUNT)).
IV_SEED, {W/8{8'hA5}}, W-bit reset value of the chain register.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  input block offered
in_ready  out  1  engine can accept a block
in_data  in  W  plaintext (encrypt) or ciphertext (decrypt)
in_key  in  W  cipher key
in_decrypt  in  1  0 = encrypt, 1 = decrypt
in_chain  in  1  1 = IV-chained mode for this block
out_valid  out  1  result block held
out_ready  in  1  consumer accepts result
out_data  out  W  result block
out_decrypt  out  1  mode tag of the result
busy  out  1  FSM not IDLE

Behaviour:
- rotl8/rotr8 = rotate the whole W-bit word by one byte. Round key k_i = rotr(K, 8*i mod W).
- Encrypt: s = P ^ (in_chain ? chain : 0). For i = 0..R-1: s = rotl8(s ^ k_i).
- Decrypt: s = C. For i = R-1..0: s = rotr8(s) ^ k_i. Result = s ^ (in_chain ? chain : 0).
- FSM states: IDLE, ROUND, DONE.
- IDLE: in_ready=1. On in_valid, latch data/key/mode/chain. Encrypt preloads the chain XOR. Decrypt sets the round key to k_{R-1} and the counter to R-1. Go to ROUND.
- ROUND: one round per cycle. Encrypt counter runs up 0..R-1; decrypt runs down R-1..0. After the last round, go to DONE.
- DONE: if the output register is empty, or is being popped this cycle (out_valid & out_ready), load the result, set out_valid, and return to IDLE. Otherwise stall in DONE with state frozen.
- Latency: with no back-pressure, out_valid rises on the (R+2)th rising edge after the accepting edge. Throughput is one block per R+2 cycles.
- The output register holds until out_valid & out_ready. out_data and out_decrypt are stable while out_valid=1 and not yet accepted.
- in_ready=1 only in IDLE. An input offered while busy is ignored, not lost; the producer holds it.
- Chain register, updated only on a chained block when its result is loaded into the output:
  - encrypt: chain <= ciphertext;
  - decrypt: chain <= the input ciphertext, latched at accept.
  - Unchained blocks leave chain untouched.
- Simultaneous pop and load in the same cycle: the new result replaces the old, and out_valid stays 1.
- Reset, also mid-operation:
  - FSM to IDLE; in-flight block discarded.
  - out_valid=0, out_data=0, out_decrypt=0, busy=0.
  - chain=IV_SEED; counters and keys zero.
  - in_ready=1 from the first edge after reset deasserts.
- ROUND_COUNT=1: a single ROUND cycle.

Decomposition:
- Package crypto_engine_pkg holds:
  - state enum (IDLE/ROUND/DONE);
  - byte-rotate functions rotl8/rotr8, parametrised on width;
  - the round-counter width function.
- One natural sub-module, crypto_round_fn: a combinational single round taking (state, round_key, decrypt) and returning next_state. It is instantiated once.

Test Plan:
Bench config for the concrete values: BLOCK_BYTES=4, ROUND_COUNT=2, IV_SEED=0xA5A5A5A5.
- Encrypt P=0x00000000, K=0x01020304, unchained -> out_data=0x02060206, out_decrypt=0; out_valid on the 4th edge after accept.
- Decrypt C=0x02060206, K=0x01020304 -> out_data=0x00000000, out_decrypt=1. Round-trip random P/K at default params -> identity.
- Chained encrypt P=0, K=0, then chained encrypt P=0xA5A5A5A5, K=0 -> outputs 0xA5A5A5A5, then 0x00000000. Chain resets to 0xA5A5A5A5 after rst.
- Hold out_ready=0 across two blocks -> second block stalls in DONE, in_ready=0, first result stable. Release out_ready -> results delivered in order with no loss.
- Assert rst during the ROUND state -> out_valid=0, busy=0, in_ready=1 next cycle; block discarded; next encrypt is correct.
